apb_master_bridge: RTL

//  Upstream APB requester feeding apb_mem. Converts a valid/ready command port into APB3 transfers:

---
 rtl/apb_pkg.sv | 24 ++
 rtl/apb_master_bridge_if.sv | 34 +++
 rtl/apb_wdog.sv | 27 ++
 rtl/apb_master_bridge.sv | 113 +++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM state encoding and command/response records.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response port plus APB3 bus of the bridge; master = bridge side, slave = agent/peripheral side.
interface apb_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // cmd: a transfer is accepted on a rising edge where cmd_valid && cmd_ready; rsp_valid is a
  // one-cycle pulse with no back-pressure, so the requester must always be able to take it.
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel1;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel1, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel1, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_wdog.sv
// Saturating ACCESS-phase wait counter; o_expired flags the last permitted wait cycle.
module apb_wdog #(
  parameter int LIMIT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CW'(LIMIT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Counter reads k-1 during the k-th enabled cycle.
  assign o_expired = i_en && (r_cnt == CW'(LIMIT - 1));
endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command port to APB3 master (SETUP, ACCESS, wait states), one transfer in flight.
// Optional ACCESS watchdog enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                i_pclk,
  input  logic                i_presetn,
  apb_master_bridge_if.master bus,
  output apb_state_e          o_state
);
  apb_state_e        r_state;
  logic              r_cmd_ready;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              w_expired;

`ifdef APB_TIMEOUT_EN
  logic w_wd_clear;
  logic w_wd_en;

  assign w_wd_clear = (r_state == SETUP);
  assign w_wd_en    = (r_state == ACCESS);

  apb_wdog #(.LIMIT(TIMEOUT)) u_wdog (
    .i_clk     (i_pclk),
    .i_rst_n   (i_presetn),
    .i_clear   (w_wd_clear),
    .i_en      (w_wd_en),
    .o_expired (w_expired)
  );
`else
  // Without the watchdog ACCESS waits forever; TIMEOUT has no effect.
  assign w_expired = (TIMEOUT < 0);
`endif

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (bus.cmd_valid && r_cmd_ready) begin
            r_state     <= SETUP;
            r_cmd_ready <= 1'b0;
            r_psel      <= 1'b1;
            r_pwrite    <= bus.cmd_write;
            r_paddr     <= bus.cmd_addr;
            r_pwdata    <= bus.cmd_wdata;
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
        end
        ACCESS: begin
          // A ready slave wins over a watchdog expiring on the same edge.
          if (bus.pready) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= bus.pslverr;
            r_rsp_rdata <= (!r_pwrite && !bus.pslverr) ? bus.prdata : '0;
          end else if (w_expired) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.psel1     = r_psel;
  assign bus.penable   = r_penable;
  assign bus.pwrite    = r_pwrite;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign o_state       = r_state;
endmodule
